spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  Byte-oriented SPI master for the FPGA clock domain; counterpart to our SPI slave.
//  Generates SCLK/CS_n/MOSI from i_Clk, samples MISO, returns each received byte with a 1-cycle DV pulse.
//  Supports multi-byte bursts with CS_n held low; all logic is synchronous to i_Clk.
// PARAMETERS
//  SPI_MODE           0  CPOL=(MODE==2|3), CPHA=(MODE==1|3); legal 0..3
//  CLKS_PER_HALF_BIT  2  i_Clk cycles per SCLK half-period; legal >=2
//  MAX_BYTES_PER_CS   4  max bytes per burst; sizes i_TX_Count ($clog2(MAX_BYTES_PER_CS+1))
//  CS_INACTIVE_CLKS   4  min i_Clk cycles CS_n stays high between bursts; legal >=1
// PORTS
//  i_Clk        in   1   system clock
//  i_Rst        in   1   reset: synchronous, active-high
//  i_TX_Count   in   CW  bytes in burst, sampled with first i_TX_DV of burst; 0 treated as 1
//  i_TX_DV      in   1   byte-valid pulse; accepted only when o_TX_Ready=1
//  i_TX_Byte    in   8   byte to send on MOSI
//  o_TX_Ready   out  1   master can accept i_TX_DV this cycle
//  o_RX_DV      out  1   1-cycle pulse, o_RX_Byte valid
//  o_RX_Byte    out  8   byte received on MISO; holds until next o_RX_DV
//  o_SPI_Clk    out  1   SCLK
//  i_SPI_MISO   in   1   serial data from slave
//  o_SPI_MOSI   out  1   serial data to slave
//  o_SPI_CS_n   out  1   chip select, active-low
// BEHAVIOUR
//  Reset (i_Rst=1 at posedge): state IDLE; o_SPI_CS_n=1, o_SPI_Clk=CPOL, o_SPI_MOSI=0, o_TX_Ready=0,
//   o_RX_DV=0, o_RX_Byte=8'h00. o_TX_Ready=1 first cycle after reset released. Reset mid-transfer aborts:
//   CS_n high, SCLK=CPOL next edge, no o_RX_DV for partial byte.
//  All outputs registered. Default bit order MSB first.
//  States: IDLE -> CS_SETUP -> XFER -> (WAIT_NEXT -> XFER)* -> CS_HOLD -> CS_GAP -> IDLE.
//  IDLE: ready=1, CS_n=1. i_TX_DV: latch byte, latch count N (0->1), ready=0, CS_n=0 next cycle, -> CS_SETUP.
//  CS_SETUP: CLKS_PER_HALF_BIT cycles, SCLK idle. CPHA=0: MOSI=bit7 driven on entry (setup before 1st edge).
//  XFER: 16 SCLK edges, one per CLKS_PER_HALF_BIT cycles; leading edge = odd edges 1,3..15.
//   CPHA=0: sample MISO on leading edges; MOSI advances on trailing edges 2..14.
//   CPHA=1: MOSI driven on leading edges; sample MISO on trailing edges.
//   After 16th edge SCLK=CPOL; o_RX_DV pulses 1 cycle after the 8th sample edge's i_Clk cycle.
//  Byte k<N done: -> WAIT_NEXT, ready=1, CS_n stays 0, SCLK idle; i_TX_DV -> XFER after
//   CLKS_PER_HALF_BIT cycles (CPHA=0 MOSI=new bit7 on entry). No timeout; CS held indefinitely.
//  Byte N done: -> CS_HOLD, CLKS_PER_HALF_BIT cycles CS_n=0, then CS_n=1, -> CS_GAP CS_INACTIVE_CLKS cycles, -> IDLE.
//  i_TX_DV while o_TX_Ready=0 ignored (no queuing, no error). i_TX_Count ignored except on burst start;
//   values > MAX_BYTES_PER_CS saturate to MAX_BYTES_PER_CS.
//  o_SPI_MOSI returns to 0 when CS_n=1. Same-cycle i_Rst and i_TX_DV: reset wins.
//  Byte timing (N=1, HB=CLKS_PER_HALF_BIT): DV accept to CS_n=0: 1 cycle; CS_n low 18*HB cycles total.
// CONFIGURATION
//  SPI_MASTER_LSB_FIRST_EN defined: TX bit0 first on MOSI, first sampled MISO bit -> o_RX_Byte[0].
//  Undefined (default): MSB first both directions (matches our SPI slave).
//  Timing, states, handshake identical in both builds.
// TESTING
//  Mode0, HB=2, N=1, send 8'hA5, slave model returns 8'h3C -> MOSI 1,0,1,0,0,1,0,1; 16 edges, SCLK period 4;
//   o_RX_DV once, o_RX_Byte=8'h3C; CS_n low 36 cycles.
//  Modes 1,2,3 same data -> SCLK idle=CPOL, sampling on correct edge, o_RX_Byte=8'h3C each mode.
//  Burst N=3 (8'h01,8'h02,8'h03), slave echoes previous byte -> CS_n low throughout, 3 o_RX_DV pulses,
//   ready high in WAIT_NEXT between bytes, CS_n high >= CS_INACTIVE_CLKS before next burst accepted.
//  i_TX_DV held high throughout a transfer -> only 1 byte accepted per ready window, no extra SCLK edges.
//  i_Rst asserted after 5th SCLK edge -> next cycle CS_n=1, SCLK=CPOL, MOSI=0, no o_RX_DV; new byte 8'hFF works.
//  SPI_MASTER_LSB_FIRST_EN build, send 8'h01, slave returns 8'h80 -> MOSI first bit 1, o_RX_Byte=8'h80.

Source files
------------

// File: rtl/spi_master.sv
// spi_master: byte-oriented SPI master clocked by i_Clk.
// Drives SCLK / CS_n / MOSI, samples MISO, and returns each received byte with a
// one-cycle o_RX_DV pulse. It supports multi-byte bursts with CS_n held low.
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift bit0 first in both directions.
// The default build shifts MSB first.
module spi_master #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int MAX_BYTES_PER_CS  = 4,
    parameter int CS_INACTIVE_CLKS  = 4
) (
    input  logic                                  i_Clk,
    input  logic                                  i_Rst,
    input  logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] i_TX_Count,
    input  logic                                  i_TX_DV,
    input  logic [7:0]                            i_TX_Byte,
    output logic                                  o_TX_Ready,
    output logic                                  o_RX_DV,
    output logic [7:0]                            o_RX_Byte,
    output logic                                  o_SPI_Clk,
    input  logic                                  i_SPI_MISO,
    output logic                                  o_SPI_MOSI,
    output logic                                  o_SPI_CS_n
);

    localparam int   CW      = $clog2(MAX_BYTES_PER_CS + 1);
    localparam logic CPOL    = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA    = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam int   CNT_MAX = (CLKS_PER_HALF_BIT > CS_INACTIVE_CLKS) ? CLKS_PER_HALF_BIT
                                                                      : CS_INACTIVE_CLKS;
    localparam int   CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_INACTIVE_CLKS - 1);
    localparam logic [CW-1:0]    MAX_N    = CW'(MAX_BYTES_PER_CS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_XFER,
        ST_WAIT_NEXT,
        ST_CS_HOLD,
        ST_CS_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       edge_q, edge_d;
    logic [CW-1:0]    left_q, left_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic             ready_q, ready_d;
    logic             rx_dv_q, rx_dv_d;
    logic [7:0]       rx_byte_q, rx_byte_d;

    logic [4:0]       edge_num;
    logic             is_sample;

`ifdef SPI_MASTER_LSB_FIRST_EN
    function automatic logic first_bit(input logic [7:0] v);
        return v[0];
    endfunction
    function automatic logic [7:0] shift_out(input logic [7:0] v);
        return {1'b0, v[7:1]};
    endfunction
    function automatic logic [7:0] shift_in(input logic [7:0] v, input logic b);
        return {b, v[7:1]};
    endfunction
`else
    function automatic logic first_bit(input logic [7:0] v);
        return v[7];
    endfunction
    function automatic logic [7:0] shift_out(input logic [7:0] v);
        return {v[6:0], 1'b0};
    endfunction
    function automatic logic [7:0] shift_in(input logic [7:0] v, input logic b);
        return {v[6:0], b};
    endfunction
`endif

    // A count of 0 is treated as 1, and counts above the limit saturate to the limit.
    function automatic logic [CW-1:0] burst_len(input logic [CW-1:0] c);
        if (c == '0)
            return CW'(1);
        else if (c > MAX_N)
            return MAX_N;
        else
            return c;
    endfunction

    // Next-state and output logic for the transfer sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        left_d    = left_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        ready_d   = ready_q;
        rx_dv_d   = 1'b0;
        rx_byte_d = rx_byte_q;
        edge_num  = edge_q + 5'd1;
        // With CPHA=0 MISO is sampled on leading (odd) edges; with CPHA=1 on trailing edges.
        is_sample = edge_num[0] ^ CPHA;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                cs_n_d  = 1'b1;
                mosi_d  = 1'b0;
                sclk_d  = CPOL;
                if (ready_q && i_TX_DV) begin
                    ready_d = 1'b0;
                    cs_n_d  = 1'b0;
                    left_d  = burst_len(i_TX_Count);
                    cnt_d   = '0;
                    state_d = ST_CS_SETUP;
                    if (CPHA == 1'b0) begin
                        mosi_d = first_bit(i_TX_Byte);
                        tx_d   = shift_out(i_TX_Byte);
                    end else begin
                        tx_d   = i_TX_Byte;
                    end
                end
            end

            ST_CS_SETUP: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d   = '0;
                    edge_d  = '0;
                    state_d = ST_XFER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_XFER: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_num;
                    if (is_sample) begin
                        rx_sh_d = shift_in(rx_sh_q, i_SPI_MISO);
                        // The eighth sample falls on edge 15 (CPHA=0) or edge 16 (CPHA=1).
                        if (edge_num >= 5'd15) begin
                            rx_byte_d = shift_in(rx_sh_q, i_SPI_MISO);
                            rx_dv_d   = 1'b1;
                        end
                    end else if (!(CPHA == 1'b0 && edge_num == 5'd16)) begin
                        mosi_d = first_bit(tx_q);
                        tx_d   = shift_out(tx_q);
                    end
                    if (edge_num == 5'd16) begin
                        if (left_q <= CW'(1)) begin
                            state_d = ST_CS_HOLD;
                        end else begin
                            left_d  = left_q - CW'(1);
                            ready_d = 1'b1;
                            state_d = ST_WAIT_NEXT;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Ready high: waiting (indefinitely) for the next byte of the burst.
            // Ready low: byte accepted, SCLK idle for one half-bit before XFER.
            ST_WAIT_NEXT: begin
                if (ready_q) begin
                    if (i_TX_DV) begin
                        ready_d = 1'b0;
                        cnt_d   = '0;
                        if (CPHA == 1'b0) begin
                            mosi_d = first_bit(i_TX_Byte);
                            tx_d   = shift_out(i_TX_Byte);
                        end else begin
                            tx_d   = i_TX_Byte;
                        end
                    end
                end else if (cnt_q == HB_LAST) begin
                    cnt_d   = '0;
                    edge_d  = '0;
                    state_d = ST_XFER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_CS_HOLD: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = ST_CS_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_CS_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            left_q    <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            sclk_q    <= CPOL;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            ready_q   <= 1'b0;
            rx_dv_q   <= 1'b0;
            rx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            left_q    <= left_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            ready_q   <= ready_d;
            rx_dv_q   <= rx_dv_d;
            rx_byte_q <= rx_byte_d;
        end
    end

    assign o_TX_Ready = ready_q;
    assign o_RX_DV    = rx_dv_q;
    assign o_RX_Byte  = rx_byte_q;
    assign o_SPI_Clk  = sclk_q;
    assign o_SPI_MOSI = mosi_q;
    assign o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: runs all four SPI modes side by side on shared stimulus.
// A bit-level slave model per instance captures MOSI and serves MISO from a byte list.
module tb_spi_master;

    localparam int HB   = 2;
    localparam int MAXB = 4;
    localparam int CI   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      tx_count = 3'd1;
    logic            tx_dv = 1'b0;
    logic [7:0]      tx_byte = 8'h00;
    logic [3:0]      ready, rx_dv, sclk, mosi, cs_n;
    logic [3:0]      miso = '0;
    logic [3:0][7:0] rx_byte;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_master #(
            .SPI_MODE(g),
            .CLKS_PER_HALF_BIT(HB),
            .MAX_BYTES_PER_CS(MAXB),
            .CS_INACTIVE_CLKS(CI)
        ) u_dut (
            .i_Clk(clk),
            .i_Rst(rst),
            .i_TX_Count(tx_count),
            .i_TX_DV(tx_dv),
            .i_TX_Byte(tx_byte),
            .o_TX_Ready(ready[g]),
            .o_RX_DV(rx_dv[g]),
            .o_RX_Byte(rx_byte[g]),
            .o_SPI_Clk(sclk[g]),
            .i_SPI_MISO(miso[g]),
            .o_SPI_MOSI(mosi[g]),
            .o_SPI_CS_n(cs_n[g])
        );
    end

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  cur_tx [64];
    logic [7:0]  resp_bytes [64];
    int unsigned init_gen = 0;
    int unsigned gen_seen = 0;

    int unsigned ptr [4], s_bits [4], mosi_n [4], rx_n [4], edges [4], falls [4];
    int unsigned low_len [4], last_low [4], high_len [4], min_high [4];
    int unsigned wait_rdy [4], idle_bad [4];
    logic [7:0]  s_sh [4];
    logic [7:0]  mosi_log [4][64];
    logic [7:0]  rx_log [4][64];
    logic        prev_sclk [4], prev_cs [4];

    // Bit i of the slave's outgoing MISO stream.
    function automatic logic resp_bit(input int unsigned i);
        logic [7:0] b;
        if (i / 8 >= 64) return 1'b0;
        b = resp_bytes[i / 8];
`ifdef SPI_MASTER_LSB_FIRST_EN
        return b[i % 8];
`else
        return b[7 - (i % 8)];
`endif
    endfunction

    // Slave models and bus monitors for all four instances.
    always @(negedge clk) begin
        if (gen_seen != init_gen) begin
            gen_seen = init_gen;
            for (int m = 0; m < 4; m++) begin
                s_bits[m] = 0; mosi_n[m] = 0; rx_n[m] = 0; edges[m] = 0; falls[m] = 0;
                low_len[m] = 0; last_low[m] = 0; high_len[m] = 0; min_high[m] = 9999;
                wait_rdy[m] = 0; idle_bad[m] = 0; s_sh[m] = 8'h00;
                prev_sclk[m] = sclk[m]; prev_cs[m] = cs_n[m];
                if (m % 2 == 0) begin
                    miso[m] = resp_bit(0);
                    ptr[m] = 1;
                end else begin
                    miso[m] = 1'b0;
                    ptr[m] = 0;
                end
            end
        end else begin
            for (int m = 0; m < 4; m++) begin
                logic cpol, cpha, lead;
                cpol = (m >= 2);
                cpha = (m % 2 == 1);
                if (cs_n[m] == 1'b0) begin
                    if (prev_cs[m]) begin
                        if (falls[m] > 0 && high_len[m] < min_high[m]) min_high[m] = high_len[m];
                        falls[m]++;
                        low_len[m] = 0;
                    end
                    low_len[m]++;
                    if (ready[m]) wait_rdy[m]++;
                    if (sclk[m] != prev_sclk[m]) begin
                        edges[m]++;
                        lead = (prev_sclk[m] == cpol);
                        if (lead != cpha) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
                            s_sh[m] = {mosi[m], s_sh[m][7:1]};
`else
                            s_sh[m] = {s_sh[m][6:0], mosi[m]};
`endif
                            s_bits[m]++;
                            if (s_bits[m] == 8) begin
                                if (mosi_n[m] < 64) mosi_log[m][mosi_n[m]] = s_sh[m];
                                mosi_n[m]++;
                                s_bits[m] = 0;
                            end
                        end else begin
                            miso[m] = resp_bit(ptr[m]);
                            ptr[m]++;
                        end
                    end
                end else begin
                    if (!prev_cs[m]) begin
                        last_low[m] = low_len[m];
                        high_len[m] = 0;
                    end
                    high_len[m]++;
                    if (mosi[m] != 1'b0) idle_bad[m]++;
                    if (sclk[m] != cpol) idle_bad[m]++;
                end
                if (rx_dv[m]) begin
                    if (rx_n[m] < 64) rx_log[m][rx_n[m]] = rx_byte[m];
                    rx_n[m]++;
                end
                prev_sclk[m] = sclk[m];
                prev_cs[m] = cs_n[m];
            end
        end
    end

    task automatic check(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s mode%0d got=%0h exp=%0h", name, m, act, exp);
        end
    endtask

    task automatic restart_slaves();
        init_gen = init_gen + 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!(ready[0] && cs_n[0]) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_idle_timeout"}, 0, (k < 3000), 1);
    endtask

    // Sends cur_tx[0..n-1] as fast as ready allows and checks the outcome against
    // resp_bytes and the expected number of CS_n bursts.
    task automatic do_test(input logic [2:0] cnt, input int unsigned n,
                           input int unsigned exp_bursts, input string name);
        int k;
        restart_slaves();
        for (int unsigned i = 0; i < n; i++) begin
            k = 0;
            while (!ready[0] && k < 1000) begin
                @(negedge clk);
                k++;
            end
            if (k >= 1000) begin
                check({name, "_ready_timeout"}, 0, 0, 1);
                return;
            end
            tx_byte  = cur_tx[i];
            tx_count = cnt;
            tx_dv    = 1'b1;
            @(negedge clk);
            tx_dv    = 1'b0;
        end
        wait_idle(name);
        for (int m = 0; m < 4; m++) begin
            check({name, "_bursts"}, m, falls[m], exp_bursts);
            check({name, "_edges"}, m, edges[m], 16 * n);
            check({name, "_mosi_n"}, m, mosi_n[m], n);
            check({name, "_rx_n"}, m, rx_n[m], n);
            check({name, "_idle_lines"}, m, idle_bad[m], 0);
            check({name, "_wait_ready"}, m, (wait_rdy[m] > 0), (n > exp_bursts));
            for (int unsigned i = 0; i < n && i < mosi_n[m] && i < rx_n[m]; i++) begin
                check({name, "_mosi"}, m, mosi_log[m][i], cur_tx[i]);
                check({name, "_rx"}, m, rx_log[m][i], resp_bytes[i]);
            end
            if (exp_bursts > 1) check({name, "_cs_gap"}, m, (min_high[m] >= CI), 1);
            if (n == 1) check({name, "_cs_low"}, m, last_low[m], 18 * HB);
        end
    endtask

    typedef struct packed {
        logic [2:0]      cnt;
        logic [2:0]      n;
        logic [3:0][7:0] tx;
        logic [3:0][7:0] resp;
        logic [2:0]      bursts;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{cnt: 3'd1, n: 3'd1, tx: {8'h00, 8'h00, 8'h00, 8'hA5}, resp: {8'h00, 8'h00, 8'h00, 8'h3C}, bursts: 3'd1};
        vecs[1] = '{cnt: 3'd3, n: 3'd3, tx: {8'h00, 8'h03, 8'h02, 8'h01}, resp: {8'h00, 8'h02, 8'h01, 8'h00}, bursts: 3'd1};
        vecs[2] = '{cnt: 3'd0, n: 3'd2, tx: {8'h00, 8'h00, 8'hC3, 8'h5A}, resp: {8'h00, 8'h00, 8'h0F, 8'h96}, bursts: 3'd2};
        vecs[3] = '{cnt: 3'd7, n: 3'd4, tx: {8'h44, 8'h33, 8'h22, 8'h11}, resp: {8'hDD, 8'hCC, 8'hBB, 8'hAA}, bursts: 3'd1};
        vecs[4] = '{cnt: 3'd1, n: 3'd1, tx: {8'h00, 8'h00, 8'h00, 8'h01}, resp: {8'h00, 8'h00, 8'h00, 8'h80}, bursts: 3'd1};
        vecs[5] = '{cnt: 3'd2, n: 3'd4, tx: {8'hF0, 8'h0F, 8'hFF, 8'h00}, resp: {8'h81, 8'h7E, 8'h00, 8'hFF}, bursts: 3'd2};

        // Reset values.
        repeat (3) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            check("rst_cs_n", m, cs_n[m], 1);
            check("rst_sclk", m, sclk[m], (m >= 2));
            check("rst_mosi", m, mosi[m], 0);
            check("rst_ready", m, ready[m], 0);
            check("rst_rx_dv", m, rx_dv[m], 0);
            check("rst_rx_byte", m, rx_byte[m], 8'h00);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 4; m++) check("ready_after_rst", m, ready[m], 1);

        // Table-driven vectors.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) begin
                cur_tx[i]     = vecs[v].tx[i];
                resp_bytes[i] = vecs[v].resp[i];
            end
            do_test(vecs[v].cnt, int'(vecs[v].n), int'(vecs[v].bursts), $sformatf("vec%0d", v));
        end

        // Randomised bursts; the burst count comes from the count-interpretation rule.
        for (int r = 0; r < 8; r++) begin
            logic [2:0]  c;
            int unsigned eff, nb;
            c   = 3'($urandom_range(0, 7));
            eff = (c == 0) ? 1 : ((c > MAXB) ? MAXB : int'(c));
            nb  = $urandom_range(1, 2);
            for (int unsigned i = 0; i < eff * nb; i++) begin
                cur_tx[i]     = 8'($urandom);
                resp_bytes[i] = 8'($urandom);
            end
            do_test(c, eff * nb, nb, $sformatf("rnd%0d", r));
        end

        // i_TX_DV held high through a whole single-byte transfer.
        begin
            int k;
            restart_slaves();
            resp_bytes[0] = 8'h3C;
            tx_byte  = 8'h5A;
            tx_count = 3'd1;
            tx_dv    = 1'b1;
            k = 0;
            while (falls[0] == 0 && k < 200) begin @(negedge clk); k++; end
            while (cs_n[0] == 1'b0 && k < 500) begin @(negedge clk); k++; end
            tx_dv = 1'b0;
            check("held_dv_timeout", 0, (k < 500), 1);
            wait_idle("held_dv");
            for (int m = 0; m < 4; m++) begin
                check("held_dv_edges", m, edges[m], 16);
                check("held_dv_bursts", m, falls[m], 1);
                check("held_dv_mosi", m, mosi_log[m][0], 8'h5A);
                check("held_dv_rx_n", m, rx_n[m], 1);
            end
        end

        // Reset after the 5th SCLK edge aborts the byte cleanly.
        begin
            int k;
            restart_slaves();
            resp_bytes[0] = 8'h3C;
            tx_byte  = 8'hA5;
            tx_count = 3'd1;
            tx_dv    = 1'b1;
            @(negedge clk);
            tx_dv = 1'b0;
            k = 0;
            while (edges[0] < 5 && k < 500) begin @(negedge clk); k++; end
            check("abort_edge_timeout", 0, (k < 500), 1);
            rst = 1'b1;
            @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                check("abort_cs_n", m, cs_n[m], 1);
                check("abort_sclk", m, sclk[m], (m >= 2));
                check("abort_mosi", m, mosi[m], 0);
                check("abort_rx_dv", m, rx_dv[m], 0);
            end
            rst = 1'b0;
            repeat (4) @(negedge clk);
            for (int m = 0; m < 4; m++) check("abort_no_rx", m, rx_n[m], 0);
            cur_tx[0]     = 8'hFF;
            resp_bytes[0] = 8'h3C;
            do_test(3'd1, 1, 1, "after_abort");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
